// File: rtl/pwm_gen_pkg.sv
// rtl/pwm_gen_pkg.sv - shared types and constants for the pwm_gen block
//
// Purpose: duty width, dead-time limit and the dead-time FSM state type,
// shared by the interface, the top and the dead-time stage.
package pwm_pkg;

  localparam int DUTY_W       = 8;
  localparam int DEADTIME_MAX = 15;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_DEAD_LH = 2'd1,
    S_HI      = 2'd2,
    S_DEAD_HL = 2'd3
  } dt_state_t;

endpackage

// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - duty-cycle update handshake between a source and pwm_gen
//
// Purpose: carries one duty value per transfer plus the apply acknowledge.
// Signals:
//   duty_in    - requested duty (high counts per 256-count period)
//   duty_valid - duty_in is valid; held by the source until accepted
//   duty_ready - pending slot empty; a transfer happens when valid && ready
//   update_ack - one-cycle pulse when the pending value becomes active
// Modports: master = duty source, slave = pwm_gen.
interface pwm_gen_if;
  import pwm_pkg::*;

  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              duty_ready;
  logic              update_ack;

  modport master (output duty_in, output duty_valid,
                  input  duty_ready, input update_ack);
  modport slave  (input  duty_in, input duty_valid,
                  output duty_ready, output update_ack);
endinterface

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - dead-time insertion for complementary PWM outputs
//
// Purpose: turns the raw compare into a high-side/low-side pair with DEADTIME
// both-low cycles at every transition. A raw reversal inside a dead window
// returns to the originating state so no runt pulse is emitted.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   raw       - unregistered PWM compare result
//   pwm_out   - high-side output (registered)
//   pwm_out_n - low-side output (registered)
// Parameter: DEADTIME (1..15) dead window length in clk cycles.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pwm_out,
  output logic pwm_out_n
);

  // Counter is loaded with DEADTIME-1 on entry; the exit happens on the edge
  // that sees zero, giving exactly DEADTIME both-low cycles.
  localparam logic [3:0] DEAD_LOAD = 4'(DEADTIME - 1);

  dt_state_t  state;
  logic [3:0] dead_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_LO;
      dead_cnt  <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      case (state)
        S_LO: begin
          if (raw) begin
            state     <= S_DEAD_LH;
            dead_cnt  <= DEAD_LOAD;
            pwm_out_n <= 1'b0;
          end
        end
        S_DEAD_LH: begin
          if (!raw) begin
            state     <= S_LO;
            pwm_out_n <= 1'b1;
          end else if (dead_cnt == 4'd0) begin
            state   <= S_HI;
            pwm_out <= 1'b1;
          end else begin
            dead_cnt <= dead_cnt - 4'd1;
          end
        end
        S_HI: begin
          if (!raw) begin
            state    <= S_DEAD_HL;
            dead_cnt <= DEAD_LOAD;
            pwm_out  <= 1'b0;
          end
        end
        S_DEAD_HL: begin
          if (raw) begin
            state   <= S_HI;
            pwm_out <= 1'b1;
          end else if (dead_cnt == 4'd0) begin
            state     <= S_LO;
            pwm_out_n <= 1'b1;
          end else begin
            dead_cnt <= dead_cnt - 4'd1;
          end
        end
        default: state <= S_LO;
      endcase
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - double-buffered PWM generator driven by an external count
//
// Purpose: compares the upstream 8-bit count against the active duty. New
// duty values land in a one-deep pending slot and are promoted only at a
// period boundary (count_in entering 0), so the waveform never glitches.
// Ports:
//   clk, rst    - clock, synchronous active-low reset
//   count_in    - free-running count from the upstream counter
//   duty        - pwm_gen_if.slave: duty_in/duty_valid/duty_ready/update_ack
//   period_tick - one-cycle pulse per detected period boundary
//   pwm_out     - PWM output (high side), one cycle after the sampled count
//   pwm_out_n   - low-side output, only with PWM_DEADTIME_EN
// Build option: PWM_DEADTIME_EN adds dead-time insertion via pwm_deadtime.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int DEADTIME = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] count_in,
  pwm_gen_if.slave          duty,
  output logic              period_tick,
`ifdef PWM_DEADTIME_EN
  output logic              pwm_out_n,
`endif
  output logic              pwm_out
);

  if ((DEADTIME < 1) || (DEADTIME > DEADTIME_MAX)) begin : g_bad_deadtime
    $error("pwm_gen: DEADTIME out of range");
  end

  logic [DUTY_W-1:0] count_q;
  logic [DUTY_W-1:0] active_duty;
  logic [DUTY_W-1:0] pending_duty;
  logic [DUTY_W-1:0] eff_duty;
  logic              pending_full;
  logic              boundary;
  logic              load;
  logic              raw;

  // Only a transition into 0 counts, so a count held at 0 yields one boundary.
  assign boundary = (count_in == '0) && (count_q != '0);
  assign load     = boundary && pending_full;

  // The boundary sample itself already uses the newly promoted duty.
  assign eff_duty = load ? pending_duty : active_duty;
  assign raw      = count_in < eff_duty;

  assign duty.duty_ready = ~pending_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q         <= '0;
      active_duty     <= '0;
      pending_duty    <= '0;
      pending_full    <= 1'b0;
      period_tick     <= 1'b0;
      duty.update_ack <= 1'b0;
    end else begin
      count_q         <= count_in;
      period_tick     <= boundary;
      duty.update_ack <= load;
      if (load) begin
        active_duty  <= pending_duty;
        pending_full <= 1'b0;
      end
      // A transfer needs an empty slot, so it never coincides with a load;
      // one arriving on a boundary waits for the next boundary.
      if (duty.duty_valid && !pending_full) begin
        pending_duty <= duty.duty_in;
        pending_full <= 1'b1;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(.DEADTIME(DEADTIME)) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .pwm_out   (pwm_out),
    .pwm_out_n (pwm_out_n)
  );
`else
  always_ff @(posedge clk) begin
    if (!rst) pwm_out <= 1'b0;
    else      pwm_out <= raw;
  end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen
module tb_pwm_gen;

  logic       clk;
  logic       rst;
  logic [7:0] count_in;
  logic       period_tick;
  logic       pwm_out;
  logic       pwm_out_n;

  pwm_gen_if bus ();

  pwm_gen #(.DEADTIME(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .duty        (bus),
    .period_tick (period_tick),
`ifdef PWM_DEADTIME_EN
    .pwm_out_n   (pwm_out_n),
`endif
    .pwm_out     (pwm_out)
  );

`ifndef PWM_DEADTIME_EN
  assign pwm_out_n = 1'b0;
`endif

  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic cnt_en  = 1'b0;
  logic [7:0] smp;
  int   acc_hi, acc_nhi, acc_both, acc_tick, acc_ack, acc_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    acc_hi = 0; acc_nhi = 0; acc_both = 0; acc_tick = 0; acc_ack = 0; acc_last = -1;
  endtask

  // One clock: sample count at the edge, look at outputs 1 time unit later,
  // then advance the count.
  task automatic cyc();
    @(posedge clk);
    smp = count_in;
    #1;
    if (pwm_out) begin acc_hi++; acc_last = int'(smp); end
    if (pwm_out_n) acc_nhi++;
    if (pwm_out && pwm_out_n) acc_both++;
    if (period_tick) acc_tick++;
    if (bus.update_ack) acc_ack++;
    if (cnt_en) count_in = count_in + 8'd1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic goto(input logic [7:0] v);
    int k;
    k = 0;
    while (count_in != v && k < 300) begin cyc(); k++; end
    if (count_in != v) chk("goto_timeout", int'(count_in), int'(v));
  endtask

  task automatic send(input logic [7:0] d);
    bus.duty_in    = d;
    bus.duty_valid = 1'b1;
    cyc();
    bus.duty_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    count_in = 8'd0;
    cnt_en = 1'b0;
    bus.duty_in = 8'd99;
    bus.duty_valid = 1'b1;
    run_n(3);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_pwm_out_n", pwm_out_n, 0);
    chk("rst_period_tick", period_tick, 0);
    chk("rst_update_ack", bus.update_ack, 0);
    chk("rst_duty_ready", bus.duty_ready, 1);
    bus.duty_valid = 1'b0;
    count_in = 8'd1;
    cnt_en = 1'b1;
    rst = 1'b1;
  endtask

  task automatic run_basic();
    do_reset();
    // first transfer: duty 64 at count 10
    goto(8'd10);
    send(8'd64);
    chk("xfer_ready_low", bus.duty_ready, 0);
    chk("xfer_no_ack", bus.update_ack, 0);
    goto(8'd0);
    clr(); run_n(256);
    chk("d64_hi", acc_hi, 64);
    chk("d64_last_hi", acc_last, 63);
    chk("d64_ticks", acc_tick, 1);
    chk("d64_acks", acc_ack, 1);
    chk("d64_ready_back", bus.duty_ready, 1);
    // extremes
    goto(8'd10);
    send(8'd0);
    goto(8'd0);
    clr(); run_n(256);
    chk("d0_hi", acc_hi, 0);
    chk("d0_acks", acc_ack, 1);
    goto(8'd10);
    send(8'd255);
    goto(8'd0);
    clr(); run_n(256);
    chk("d255_hi", acc_hi, 255);
    chk("d255_last_hi", acc_last, 254);
    chk("d255_low_at_255", pwm_out, 0);
    // backpressure: 128 pending, 32 held on the bus
    goto(8'd10);
    send(8'd128);
    bus.duty_in = 8'd32;
    bus.duty_valid = 1'b1;
    goto(8'd0);
    chk("bp_ready_held_low", bus.duty_ready, 0);
    cyc();
    chk("bp_ack_at_boundary", bus.update_ack, 1);
    chk("bp_pwm_at_0", pwm_out, 1);
    chk("bp_ready_after_load", bus.duty_ready, 1);
    cyc();
    bus.duty_valid = 1'b0;
    chk("bp_second_xfer", bus.duty_ready, 0);
    clr(); run_n(254);
    chk("bp_d128_hi_rest", acc_hi, 126);
    chk("bp_no_extra_ack", acc_ack, 0);
    clr(); run_n(256);
    chk("bp_d32_hi", acc_hi, 32);
    chk("bp_d32_ack", acc_ack, 1);
    // boundary collision: 200 transferred on the edge sampling count 0
    send(8'd200);
    chk("col_no_ack", bus.update_ack, 0);
    chk("col_tick", period_tick, 1);
    chk("col_pending", bus.duty_ready, 0);
    chk("col_old_duty_at_0", pwm_out, 1);
    clr(); run_n(255);
    chk("col_old_duty_hi", acc_hi, 31);
    clr(); run_n(256);
    chk("col_d200_hi", acc_hi, 200);
    chk("col_d200_ack", acc_ack, 1);
    // upstream counter held at 0
    cnt_en = 1'b0;
    clr(); run_n(20);
    chk("hold0_ticks", acc_tick, 1);
    chk("hold0_acks", acc_ack, 0);
    count_in = 8'd1;
    cnt_en = 1'b1;
    // mid-period reset discards pending
    goto(8'd10);
    send(8'd100);
    goto(8'd50);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("midrst_pwm_out", pwm_out, 0);
    chk("midrst_ready", bus.duty_ready, 1);
    chk("midrst_ack", bus.update_ack, 0);
    goto(8'd0);
    clr(); run_n(256);
    chk("midrst_hi", acc_hi, 0);
    chk("midrst_acks", acc_ack, 0);
    chk("midrst_ticks", acc_tick, 1);
  endtask

  task automatic run_dead();
    do_reset();
    goto(8'd10);
    send(8'd64);
    goto(8'd0);
    clr();
    run_n(10);
    send(8'd2);
    run_n(245);
    chk("dt64_hi", acc_hi, 60);
    chk("dt64_last_hi", acc_last, 63);
    chk("dt64_n_hi", acc_nhi, 188);
    chk("dt64_both", acc_both, 0);
    chk("dt64_acks", acc_ack, 1);
    clr(); run_n(256);
    chk("dt2_hi", acc_hi, 0);
    chk("dt2_n_hi", acc_nhi, 254);
    chk("dt2_both", acc_both, 0);
    chk("dt2_acks", acc_ack, 1);
  endtask

  initial begin
    rst = 1'b0;
    count_in = 8'd0;
    bus.duty_in = 8'd0;
    bus.duty_valid = 1'b0;
`ifdef PWM_DEADTIME_EN
    run_dead();
`else
    run_basic();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
